// File: rtl/wb_master_pkg.sv
// Shared definitions for the Wishbone burst master: FSM state encoding,
// completion status codes and a small state-decoding helper.
package wb_master_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_WD = 2'd1,
    STROBE  = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERR     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  // True in the states that own the bus (cyc_o high).
  function automatic logic is_bus_state(input state_t s);
    return (s == WAIT_WD) || (s == STROBE);
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Counts strobe cycles that have not been terminated by the slave.
// expired_o is raised during the TIMEOUT-th consecutive enabled cycle, so a
// master that aborts on it keeps stb_o high for exactly TIMEOUT cycles.
// TIMEOUT = 0 disables the watchdog entirely.
module wb_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  // Count enabled cycles; clear has priority so each new beat starts from zero.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= '0;
    end else if (enable_i) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // r_count holds the number of earlier cycles, so LIMIT marks the last allowed one.
  assign expired_o = (TIMEOUT != 0) && enable_i && (r_count == LIMIT);

endmodule

// File: rtl/wishbone_burst_master.sv
// Wishbone classic master running 1..2^BLEN_W single-beat cycles at
// incrementing addresses for one host command, with byte selects, err_i
// termination, a strobe watchdog and a held completion status.
module wishbone_burst_master
  import wb_master_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SEL_W   = DATA_W / 8,
  parameter int BLEN_W  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [SEL_W-1:0]  cmd_sel_i,
  input  logic [BLEN_W-1:0] cmd_len_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              done_o,
  output logic [1:0]        status_o,
  output logic [ADDR_W-1:0] adr_o,
  output logic [DATA_W-1:0] dat_o,
  output logic [SEL_W-1:0]  sel_o,
  output logic              we_o,
  output logic              cyc_o,
  output logic              stb_o,
  input  logic [DATA_W-1:0] dat_i,
  input  logic              ack_i,
  input  logic              err_i
);

  state_t r_state;
  state_t w_state_next;

  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_dat;
  logic [SEL_W-1:0]  r_sel;
  logic [BLEN_W-1:0] r_len;
  logic [BLEN_W-1:0] r_beat;
  logic              r_cmd_we;
  logic              r_we;
  logic              r_cyc;
  logic              r_stb;
  logic              r_cmd_ready;
  logic              r_wr_ready;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_done;
  logic [1:0]        r_status;

  logic       w_accept;
  logic       w_wr_take;
  logic       w_ack;
  logic       w_err;
  logic       w_last;
  logic       w_expired;
  logic       w_tmo_clear;
  logic       w_tmo_enable;
  logic       w_adr_step;
  logic       w_we_next;
  logic [1:0] w_status_code;

  // Handshakes and bus terminations; ack/err only matter while strobing,
  // and err takes precedence over a simultaneous ack.
  assign w_accept     = (r_state == IDLE) && r_cmd_ready && cmd_valid_i;
  assign w_wr_take    = (r_state == WAIT_WD) && r_wr_ready && wr_valid_i;
  assign w_err        = (r_state == STROBE) && err_i;
  assign w_ack        = (r_state == STROBE) && ack_i && !err_i;
  assign w_last       = (r_beat == r_len);
  assign w_tmo_enable = (r_state == STROBE);
  assign w_tmo_clear  = (r_state != STROBE) || ack_i || err_i;
  assign w_we_next    = w_accept ? cmd_we_i : r_cmd_we;

  wb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (w_tmo_clear),
    .enable_i  (w_tmo_enable),
    .expired_o (w_expired)
  );

  // Next-state decode, completion code and the per-beat address step.
  always_comb begin
    w_state_next  = r_state;
    w_status_code = ST_OK;
    w_adr_step    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = cmd_we_i ? WAIT_WD : STROBE;
        end
      end
      WAIT_WD: begin
        if (w_wr_take) begin
          w_state_next = STROBE;
        end
      end
      STROBE: begin
        if (w_err) begin
          w_state_next  = DONE;
          w_status_code = ST_ERR;
        end else if (w_ack) begin
          if (w_last) begin
            w_state_next = DONE;
          end else begin
            w_adr_step   = 1'b1;
            w_state_next = r_cmd_we ? WAIT_WD : STROBE;
          end
        end else if (w_expired) begin
          w_state_next  = DONE;
          w_status_code = ST_TIMEOUT;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Command capture, address/beat advance and write-data latch.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_adr    <= '0;
      r_sel    <= '0;
      r_len    <= '0;
      r_beat   <= '0;
      r_cmd_we <= 1'b0;
      r_dat    <= '0;
    end else begin
      if (w_accept) begin
        r_adr    <= cmd_addr_i;
        r_sel    <= cmd_sel_i;
        r_len    <= cmd_len_i;
        r_cmd_we <= cmd_we_i;
        r_beat   <= '0;
      end else if (w_adr_step) begin
        r_adr  <= r_adr + ADDR_W'(SEL_W);
        r_beat <= r_beat + BLEN_W'(1);
      end
      if (w_wr_take) begin
        r_dat <= wr_data_i;
      end
    end
  end

  // Registered control outputs, decoded from the state being entered.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_wr_ready  <= 1'b0;
      r_done      <= 1'b0;
      r_status    <= ST_OK;
    end else begin
      r_cyc       <= is_bus_state(w_state_next);
      r_stb       <= (w_state_next == STROBE);
      r_we        <= is_bus_state(w_state_next) && w_we_next;
      r_cmd_ready <= (w_state_next == IDLE);
      r_wr_ready  <= (w_state_next == WAIT_WD);
      r_done      <= (w_state_next == DONE);
      if (w_state_next == DONE) begin
        r_status <= w_status_code;
      end
    end
  end

  // Read beat return: one pulse on the cycle after each acked read beat.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_ack && !r_cmd_we;
      if (w_ack && !r_cmd_we) begin
        r_rd_data <= dat_i;
      end
    end
  end

  assign cmd_ready_o = r_cmd_ready;
  assign wr_ready_o  = r_wr_ready;
  assign rd_valid_o  = r_rd_valid;
  assign rd_data_o   = r_rd_data;
  assign done_o      = r_done;
  assign status_o    = r_status;
  assign adr_o       = r_adr;
  assign dat_o       = r_dat;
  assign sel_o       = r_sel;
  assign we_o        = r_we;
  assign cyc_o       = r_cyc;
  assign stb_o       = r_stb;

endmodule

// File: tb/tb_wishbone_burst_master.sv
// Randomized bench for wishbone_burst_master: a negedge agent models the
// slave, the write-data source and the output monitor; each command's
// expected bus trace is derived from its per-beat response plan.
module tb_wishbone_burst_master;

  localparam int TMO = 8;

  logic        clk;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [31:0] cmd_addr_i;
  logic [3:0]  cmd_sel_i;
  logic [3:0]  cmd_len_i;
  logic        wr_valid_i;
  logic        wr_ready_o;
  logic [31:0] wr_data_i;
  logic        rd_valid_o;
  logic [31:0] rd_data_o;
  logic        done_o;
  logic [1:0]  status_o;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;
  logic        we_o;
  logic        cyc_o;
  logic        stb_o;
  logic [31:0] dat_i;
  logic        ack_i;
  logic        err_i;

  wishbone_burst_master #(
    .ADDR_W (32), .DATA_W (32), .SEL_W (4), .BLEN_W (4), .TIMEOUT (TMO)
  ) dut (
    .clk_i (clk), .rst_i (rst_i),
    .cmd_valid_i (cmd_valid_i), .cmd_ready_o (cmd_ready_o), .cmd_we_i (cmd_we_i),
    .cmd_addr_i (cmd_addr_i), .cmd_sel_i (cmd_sel_i), .cmd_len_i (cmd_len_i),
    .wr_valid_i (wr_valid_i), .wr_ready_o (wr_ready_o), .wr_data_i (wr_data_i),
    .rd_valid_o (rd_valid_o), .rd_data_o (rd_data_o),
    .done_o (done_o), .status_o (status_o),
    .adr_o (adr_o), .dat_o (dat_o), .sel_o (sel_o), .we_o (we_o),
    .cyc_o (cyc_o), .stb_o (stb_o),
    .dat_i (dat_i), .ack_i (ack_i), .err_i (err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-beat plan: response 0 = ack, 1 = err (with ack), 2 = never respond.
  int          plan_wait [16];
  int          plan_resp [16];
  int          plan_gap  [16];
  logic [31:0] plan_rdata[16];
  logic [31:0] plan_wdata[16];

  // Observations gathered by the agent.
  logic [31:0] rd_q[$];
  logic [31:0] adr_q[$];
  logic [31:0] wd_q[$];
  logic [3:0]  sel_q[$];
  int          done_seen;
  logic [1:0]  obs_status;
  logic        obs_cyc_done;
  logic        obs_rdv_done;
  int          stb_cnt;
  int          wr_hs;

  // Agent state.
  int   s_beat, waited, wd_idx, wd_gap, act_len;
  logic resp_pending, hs_pending, wd_on;

  int n_cmp = 0;
  int n_bad = 0;
  int cmd_no = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Agent: monitor, slave and write-data source, all on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        ack_i = 1'b0; err_i = 1'b0; wr_valid_i = 1'b0;
        resp_pending = 1'b0; hs_pending = 1'b0;
      end else begin
        if (rd_valid_o) rd_q.push_back(rd_data_o);
        if (done_o) begin
          done_seen++;
          obs_status   = status_o;
          obs_cyc_done = cyc_o;
          obs_rdv_done = rd_valid_o;
        end
        if (stb_o) stb_cnt++;
        if (resp_pending) begin
          resp_pending = 1'b0; ack_i = 1'b0; err_i = 1'b0;
          s_beat++; waited = 0;
        end
        if (cyc_o && stb_o) begin
          if (s_beat < 16 && plan_resp[s_beat] != 2 && waited == plan_wait[s_beat]) begin
            ack_i = 1'b1;
            err_i = (plan_resp[s_beat] == 1);
            dat_i = plan_rdata[s_beat];
            adr_q.push_back(adr_o);
            sel_q.push_back(sel_o);
            if (we_o) wd_q.push_back(dat_o);
            resp_pending = 1'b1;
          end else begin
            waited++;
          end
        end
        if (hs_pending) begin
          hs_pending = 1'b0; wd_idx++; wr_valid_i = 1'b0;
          if (wd_idx < 16) wd_gap = plan_gap[wd_idx];
        end
        if (wd_on && wd_idx <= act_len) begin
          if (wd_gap > 0) begin
            wd_gap--; wr_valid_i = 1'b0;
          end else begin
            wr_valid_i = 1'b1;
            wr_data_i  = plan_wdata[wd_idx];
            if (wr_ready_o) begin
              hs_pending = 1'b1; wr_hs++;
            end
          end
        end
      end
    end
  end

  task automatic random_plan();
    for (int i = 0; i < 16; i++) begin
      plan_wait[i]  = $urandom_range(0, 4);
      plan_resp[i]  = 0;
      plan_gap[i]   = $urandom_range(0, 3);
      plan_rdata[i] = $urandom;
      plan_wdata[i] = $urandom;
    end
  endtask

  task automatic clear_obs(input logic we, input int len);
    rd_q.delete(); adr_q.delete(); wd_q.delete(); sel_q.delete();
    done_seen = 0; obs_status = 2'b11; obs_cyc_done = 1'b1; obs_rdv_done = 1'b0;
    stb_cnt = 0; wr_hs = 0; s_beat = 0; waited = 0;
    wd_idx = 0; wd_gap = plan_gap[0]; act_len = len; wd_on = we;
  endtask

  task automatic issue_cmd(input logic we, input logic [31:0] addr, input logic [3:0] sel, input int len);
    bit got;
    got = 1'b0;
    cmd_we_i = we; cmd_addr_i = addr; cmd_sel_i = sel; cmd_len_i = 4'(len);
    cmd_valid_i = 1'b1;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (cmd_ready_o) got = 1'b1;
    end
    if (!got) check_eq("cmd_ready_wait", 0, 1);
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic run_cmd(input logic we, input logic [31:0] addr, input logic [3:0] sel, input int len);
    logic [31:0] exp_addr[$];
    logic [31:0] exp_rd[$];
    logic [1:0]  exp_st;
    int          exp_stb, exp_hs;
    bit          got;
    clear_obs(we, len);
    issue_cmd(we, addr, sel, len);
    got = 1'b0;
    for (int c = 0; c < 1000 && !got; c++) begin
      @(posedge clk);
      if (done_seen != 0) got = 1'b1;
    end
    if (!got) check_eq("done_wait", 0, 1);
    repeat (3) @(posedge clk);
    #1;
    wd_on = 1'b0; wr_valid_i = 1'b0;
    // Expected trace from the beat plan.
    exp_st = 2'b00; exp_stb = 0; exp_hs = 0;
    for (int i = 0; i <= len; i++) begin
      if (we) exp_hs++;
      if (plan_resp[i] == 2) begin
        exp_st = 2'b10; exp_stb += TMO; break;
      end
      exp_stb += plan_wait[i] + 1;
      exp_addr.push_back(addr + 32'(4 * i));
      if (plan_resp[i] == 1) begin
        exp_st = 2'b01; break;
      end
      if (!we) exp_rd.push_back(plan_rdata[i]);
    end
    cmd_no++;
    $display("cmd %0d: we=%0d addr=%08h sel=%h len=%0d beats=%0d status=%0d exp_status=%0d",
             cmd_no, we, addr, sel, len, adr_q.size(), obs_status, exp_st);
    check_eq("done_count", done_seen, 1);
    check_eq("status", obs_status, exp_st);
    check_eq("cyc_at_done", obs_cyc_done, 0);
    check_eq("rdv_with_done", obs_rdv_done, (!we && exp_st == 2'b00));
    check_eq("stb_cycles", stb_cnt, exp_stb);
    check_eq("beat_count", adr_q.size(), exp_addr.size());
    for (int i = 0; i < adr_q.size() && i < exp_addr.size(); i++) begin
      check_eq("adr", adr_q[i], exp_addr[i]);
      check_eq("sel", sel_q[i], sel);
      if (we && i < wd_q.size()) check_eq("wdat", wd_q[i], plan_wdata[i]);
    end
    if (we) begin
      check_eq("wdat_count", wd_q.size(), exp_addr.size());
      check_eq("wr_handshakes", wr_hs, exp_hs);
    end
    check_eq("rd_count", rd_q.size(), exp_rd.size());
    for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++) begin
      check_eq("rd_data", rd_q[i], exp_rd[i]);
    end
  endtask

  initial begin
    bit got;
    int roll;
    logic        r_we;
    logic [31:0] r_addr;
    rst_i = 1'b0; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = '0;
    cmd_sel_i = '0; cmd_len_i = '0; wr_valid_i = 1'b0; wr_data_i = '0;
    dat_i = '0; ack_i = 1'b0; err_i = 1'b0;
    wd_on = 1'b0; act_len = 0; wd_idx = 0; wd_gap = 0; s_beat = 0; waited = 0;
    resp_pending = 1'b0; hs_pending = 1'b0;
    random_plan();
    clear_obs(1'b0, 0);

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cmd_ready", cmd_ready_o, 0);
    check_eq("rst_cyc", cyc_o, 0);
    check_eq("rst_stb", stb_o, 0);
    check_eq("rst_done", done_o, 0);
    check_eq("rst_status", status_o, 0);
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("idle_cmd_ready", cmd_ready_o, 1);

    // 1: single read, two wait states.
    random_plan();
    plan_wait[0] = 2; plan_rdata[0] = 32'hDEADBEEF;
    run_cmd(1'b0, 32'h0000_0100, 4'hF, 0);

    // 2: 4-beat write with a 3-cycle data stall before beat 2.
    random_plan();
    for (int i = 0; i < 16; i++) plan_gap[i] = 0;
    plan_gap[1] = 3;
    run_cmd(1'b1, 32'h0000_2000, 4'hF, 3);

    // 3: 4-beat read, err together with ack on beat 3.
    random_plan();
    plan_resp[2] = 1;
    run_cmd(1'b0, 32'h0000_3000, 4'hF, 3);

    // 4: silent slave, watchdog abort.
    random_plan();
    plan_resp[0] = 2;
    run_cmd(1'b0, 32'h0000_4000, 4'h3, 0);
    check_eq("tmo_bus_released", cyc_o, 0);

    // 5: address wrap across the top of the space.
    random_plan();
    run_cmd(1'b0, 32'hFFFF_FFFC, 4'hF, 1);

    // 6: reset in the middle of a read burst.
    random_plan();
    for (int i = 0; i < 16; i++) plan_wait[i] = 3;
    clear_obs(1'b0, 3);
    issue_cmd(1'b0, 32'h0000_6000, 4'hF, 3);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (stb_o) got = 1'b1;
    end
    check_eq("rst6_stb_seen", got, 1);
    @(negedge clk);
    #2;
    rst_i = 1'b0;
    #1;
    check_eq("rst6_cyc", cyc_o, 0);
    check_eq("rst6_stb", stb_o, 0);
    check_eq("rst6_we", we_o, 0);
    check_eq("rst6_adr", adr_o, 0);
    check_eq("rst6_cmd_ready", cmd_ready_o, 0);
    check_eq("rst6_rd_valid", rd_valid_o, 0);
    check_eq("rst6_done", done_o, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_eq("rst6_ready_after", cmd_ready_o, 1);
    check_eq("rst6_no_done", done_seen, 0);
    random_plan();
    run_cmd(1'b0, 32'h0000_6100, 4'hF, 0);

    // Random commands.
    for (int n = 0; n < 40; n++) begin
      random_plan();
      for (int i = 0; i < 16; i++) begin
        roll = $urandom_range(0, 99);
        if (roll < 4) plan_resp[i] = 1;
        else if (roll < 8) plan_resp[i] = 2;
      end
      r_we   = 1'($urandom_range(0, 1));
      r_addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                            : 32'($urandom);
      run_cmd(r_we, r_addr, 4'($urandom_range(0, 15)), $urandom_range(0, 15));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
